// File: rtl/rename_ckpt_if.sv
// Decode-to-rename bundle: rename group, retire frees, writeback wakeups and branch recovery,
// plus the renamed group returned to dispatch.
interface rename_ckpt_if #(
  parameter int ARN_BITS     = 6,
  parameter int PRN_BITS     = 6,
  parameter int WIDTH        = 2,
  parameter int MAX_OPERANDS = 3,
  parameter int WB_PORTS     = 4,
  parameter int FREE_PORTS   = 3,
  parameter int CKPT_COUNT   = 4
);
  localparam int CKPT_BITS = $clog2(CKPT_COUNT);

  logic                                                in_valid;
  logic                                                stall;
  logic [WIDTH-1:0][MAX_OPERANDS-1:0][ARN_BITS-1:0]    arn_src;
  logic [WIDTH-1:0][MAX_OPERANDS-1:0][ARN_BITS-1:0]    arn_dst;
  logic                                                ckpt_req;
  logic [FREE_PORTS-1:0]                               free_valid;
  logic [FREE_PORTS-1:0][PRN_BITS-1:0]                 free_prn;
  logic [WB_PORTS-1:0]                                 wb_valid;
  logic [WB_PORTS-1:0][PRN_BITS-1:0]                   wb_prn;
  logic                                                flush_valid;
  logic [CKPT_BITS-1:0]                                flush_ckpt;
  logic                                                ckpt_release;

  logic                                                out_valid;
  logic [CKPT_BITS-1:0]                                ckpt_id;
  logic [WIDTH-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]    prn_src;
  logic [WIDTH-1:0][MAX_OPERANDS-1:0]                  prn_src_valid;
  logic [WIDTH-1:0][MAX_OPERANDS-1:0]                  prn_src_ready;
  logic [WIDTH-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]    prn_dst;
  logic [WIDTH-1:0][MAX_OPERANDS-1:0]                  prn_dst_valid;
  logic [WIDTH-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]    old_prn;
  logic [PRN_BITS:0]                                   free_count;

  modport master (
    output in_valid, stall, arn_src, arn_dst, ckpt_req, free_valid, free_prn,
           wb_valid, wb_prn, flush_valid, flush_ckpt, ckpt_release,
    input  out_valid, ckpt_id, prn_src, prn_src_valid, prn_src_ready,
           prn_dst, prn_dst_valid, old_prn, free_count
  );

  modport slave (
    input  in_valid, stall, arn_src, arn_dst, ckpt_req, free_valid, free_prn,
           wb_valid, wb_prn, flush_valid, flush_ckpt, ckpt_release,
    output out_valid, ckpt_id, prn_src, prn_src_valid, prn_src_ready,
           prn_dst, prn_dst_valid, old_prn, free_count
  );
endinterface

// File: rtl/rename_ckpt.sv
// Superscalar register renamer with circular free list, in-group bypass and
// map-table checkpoints for single-cycle branch-flush recovery.
module rename_ckpt #(
  parameter int ARN_BITS     = 6,
  parameter int PRN_BITS     = 6,
  parameter int WIDTH        = 2,
  parameter int MAX_OPERANDS = 3,
  parameter int WB_PORTS     = 4,
  parameter int FREE_PORTS   = 3,
  parameter int CKPT_COUNT   = 4,
  parameter int PREALLOC_PRS = 33
) (
  input logic         clk,
  input logic         rst,
  rename_ckpt_if.slave bus
);
  localparam int DEPTH     = 1 << PRN_BITS;
  localparam int NARN      = 1 << ARN_BITS;
  localparam int SLOTS     = WIDTH * MAX_OPERANDS;
  localparam int CKPT_BITS = $clog2(CKPT_COUNT);
  localparam logic [ARN_BITS-1:0] ARN_NONE = ARN_BITS'(NARN - 2);
  localparam logic [ARN_BITS-1:0] ARN_ZERO = ARN_BITS'(NARN - 1);
  localparam logic [CKPT_BITS:0]  CKPT_FULL = (CKPT_BITS+1)'(CKPT_COUNT);

  logic [PRN_BITS-1:0] map_reg       [NARN];
  logic [DEPTH-1:0]    ready_reg;
  logic [PRN_BITS-1:0] free_list_reg [DEPTH];
  logic [PRN_BITS-1:0] head_reg, tail_reg;
  logic [PRN_BITS:0]   count_reg;
  logic [PRN_BITS-1:0] ckpt_map_reg  [CKPT_COUNT][NARN];
  logic [PRN_BITS-1:0] ckpt_head_reg [CKPT_COUNT];
  logic [CKPT_BITS-1:0] ck_rd_reg, ck_wr_reg;
  logic [CKPT_BITS:0]   ck_count_reg;

  logic [ARN_BITS-1:0] src_arn  [SLOTS];
  logic [ARN_BITS-1:0] dst_arn  [SLOTS];
  logic [SLOTS-1:0]    dst_live;
  logic [PRN_BITS-1:0] pop_idx  [SLOTS];
  logic [PRN_BITS-1:0] new_prn  [SLOTS];
  logic [PRN_BITS-1:0] old_flat [SLOTS];
  logic [PRN_BITS-1:0] src_prn  [SLOTS];
  logic [SLOTS-1:0]    src_vld;
  logic [SLOTS-1:0]    src_rdy;
  logic [PRN_BITS-1:0] map_next [NARN];
  logic [PRN_BITS:0]   alloc_n;
  logic [PRN_BITS:0]   free_n;
  logic [PRN_BITS-1:0] push_idx [FREE_PORTS];
  logic [PRN_BITS-1:0] tail_next;
  logic [PRN_BITS-1:0] head_next;
  logic [PRN_BITS:0]   count_next;
  logic [DEPTH-1:0]    wb_mask;
  logic [DEPTH-1:0]    alloc_mask;
  logic [DEPTH-1:0]    ready_next;
  logic                ck_full, release_ok, push, fire, out_valid;
  logic [CKPT_BITS-1:0] flush_span;
  logic [CKPT_BITS-1:0] ck_rd_next, ck_wr_next;
  logic [CKPT_BITS:0]   ck_count_next;

  // Flatten the group so slot k = inst*MAX_OPERANDS + operand gives program order.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_flat
    assign src_arn[gi]  = bus.arn_src[gi / MAX_OPERANDS][gi % MAX_OPERANDS];
    assign dst_arn[gi]  = bus.arn_dst[gi / MAX_OPERANDS][gi % MAX_OPERANDS];
    assign dst_live[gi] = (dst_arn[gi] != ARN_NONE) && (dst_arn[gi] != ARN_ZERO);
    assign bus.prn_src[gi / MAX_OPERANDS][gi % MAX_OPERANDS]       = src_prn[gi];
    assign bus.prn_src_valid[gi / MAX_OPERANDS][gi % MAX_OPERANDS] = src_vld[gi];
    assign bus.prn_src_ready[gi / MAX_OPERANDS][gi % MAX_OPERANDS] = src_rdy[gi];
    assign bus.prn_dst[gi / MAX_OPERANDS][gi % MAX_OPERANDS]       = dst_live[gi] ? new_prn[gi] : '0;
    assign bus.prn_dst_valid[gi / MAX_OPERANDS][gi % MAX_OPERANDS] = dst_live[gi];
    assign bus.old_prn[gi / MAX_OPERANDS][gi % MAX_OPERANDS]       = old_flat[gi];
  end

  always_comb begin
    alloc_n    = '0;
    alloc_mask = '0;
    for (int k = 0; k < SLOTS; k++) begin
      pop_idx[k] = head_reg + alloc_n[PRN_BITS-1:0];
      new_prn[k] = free_list_reg[pop_idx[k]];
      if (dst_live[k]) begin
        alloc_n = alloc_n + (PRN_BITS+1)'(1);
        alloc_mask[new_prn[k]] = 1'b1;
      end
    end
  end

  // Walking the map in program order gives old_prn chaining and youngest-writer-wins.
  always_comb begin
    for (int a = 0; a < NARN; a++) map_next[a] = map_reg[a];
    for (int k = 0; k < SLOTS; k++) begin
      old_flat[k] = '0;
      if (dst_live[k]) begin
        old_flat[k] = map_next[dst_arn[k]];
        map_next[dst_arn[k]] = new_prn[k];
      end
    end
  end

  always_comb begin
    wb_mask = '0;
    for (int w = 0; w < WB_PORTS; w++)
      if (bus.wb_valid[w]) wb_mask[bus.wb_prn[w]] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      src_prn[k] = '1;
      src_vld[k] = 1'b0;
      src_rdy[k] = 1'b0;
      if (src_arn[k] == ARN_ZERO) begin
        src_prn[k] = '0;
        src_rdy[k] = 1'b1;
      end else if (src_arn[k] != ARN_NONE) begin
        src_prn[k] = map_reg[src_arn[k]];
        src_vld[k] = 1'b1;
        src_rdy[k] = ready_reg[src_prn[k]] | wb_mask[src_prn[k]];
        for (int j = 0; j < SLOTS; j++) begin
          if ((j / MAX_OPERANDS) < (k / MAX_OPERANDS) && dst_live[j] && dst_arn[j] == src_arn[k]) begin
            src_prn[k] = new_prn[j];
            src_rdy[k] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    free_n = '0;
    for (int f = 0; f < FREE_PORTS; f++) begin
      push_idx[f] = tail_reg + free_n[PRN_BITS-1:0];
      if (bus.free_valid[f]) free_n = free_n + (PRN_BITS+1)'(1);
    end
  end

  assign ck_full    = (ck_count_reg == CKPT_FULL);
  assign out_valid  = !rst && bus.in_valid && !bus.flush_valid && (alloc_n <= count_reg)
                      && !(bus.ckpt_req && ck_full);
  assign fire       = out_valid && !bus.stall;
  assign push       = fire && bus.ckpt_req;
  assign release_ok = bus.ckpt_release && (ck_count_reg != '0);
  assign tail_next  = tail_reg + free_n[PRN_BITS-1:0];
  assign ready_next = (ready_reg | wb_mask) & ~(fire ? alloc_mask : '0);

  always_comb begin
    head_next  = head_reg;
    count_next = count_reg + free_n - (fire ? alloc_n : '0);
    if (bus.flush_valid) begin
      head_next  = ckpt_head_reg[bus.flush_ckpt];
      count_next = {1'b0, tail_next - head_next};
    end else if (fire) begin
      head_next = head_reg + alloc_n[PRN_BITS-1:0];
    end
  end

  // A live flush target means at least one slot is held, so a zero span is a full FIFO.
  always_comb begin
    flush_span    = bus.flush_ckpt + CKPT_BITS'(1) - ck_rd_reg;
    ck_rd_next    = ck_rd_reg + CKPT_BITS'(release_ok);
    ck_wr_next    = ck_wr_reg + CKPT_BITS'(push);
    ck_count_next = ck_count_reg + (CKPT_BITS+1)'(push) - (CKPT_BITS+1)'(release_ok);
    if (bus.flush_valid) begin
      ck_wr_next    = bus.flush_ckpt + CKPT_BITS'(1);
      ck_count_next = ((flush_span == '0) ? CKPT_FULL : {1'b0, flush_span})
                      - (CKPT_BITS+1)'(release_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NARN; a++)
        map_reg[a] <= (a < PREALLOC_PRS) ? PRN_BITS'(a) : '0;
      for (int p = 0; p < DEPTH; p++) begin
        ready_reg[p]     <= (p < PREALLOC_PRS);
        free_list_reg[p] <= PRN_BITS'(p + PREALLOC_PRS);
      end
      head_reg     <= '0;
      tail_reg     <= PRN_BITS'(DEPTH - PREALLOC_PRS);
      count_reg    <= (PRN_BITS+1)'(DEPTH - PREALLOC_PRS);
      ck_rd_reg    <= '0;
      ck_wr_reg    <= '0;
      ck_count_reg <= '0;
    end else begin
      for (int f = 0; f < FREE_PORTS; f++)
        if (bus.free_valid[f]) free_list_reg[push_idx[f]] <= bus.free_prn[f];
      if (bus.flush_valid) begin
        for (int a = 0; a < NARN; a++) map_reg[a] <= ckpt_map_reg[bus.flush_ckpt][a];
      end else if (fire) begin
        for (int a = 0; a < NARN; a++) map_reg[a] <= map_next[a];
      end
      ready_reg    <= ready_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      ck_rd_reg    <= ck_rd_next;
      ck_wr_reg    <= ck_wr_next;
      ck_count_reg <= ck_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      for (int a = 0; a < NARN; a++) ckpt_map_reg[ck_wr_reg][a] <= map_next[a];
      ckpt_head_reg[ck_wr_reg] <= head_next;
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.ckpt_id    = ck_wr_reg;
  assign bus.free_count = count_reg;
endmodule

// File: tb/tb_rename_ckpt.sv
// Directed bench for rename_ckpt: rename/bypass, free-list exhaustion, writeback wakeup,
// checkpoint/flush recovery and checkpoint FIFO limits.
module tb_rename_ckpt;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rename_ckpt_if bus ();
  rename_ckpt dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-16s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid     = 1'b0;
    bus.stall        = 1'b0;
    bus.ckpt_req     = 1'b0;
    bus.free_valid   = '0;
    bus.free_prn     = '0;
    bus.wb_valid     = '0;
    bus.wb_prn       = '0;
    bus.flush_valid  = 1'b0;
    bus.flush_ckpt   = '0;
    bus.ckpt_release = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 3; s++) begin
        bus.arn_src[i][s] = 6'd62;
        bus.arn_dst[i][s] = 6'd62;
      end
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    clear_in();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    tick();
    tick();
    rst = 1'b0;
    clear_in();
    #1;
    chk("rst_free_count", 32'(bus.free_count), 31);
    chk("rst_ckpt_id", 32'(bus.ckpt_id), 0);

    // Basic rename with in-group bypass and special ARNs
    bus.in_valid = 1'b1;
    bus.arn_dst[0][0] = 6'd1;
    bus.arn_src[0][0] = 6'd1;
    bus.arn_src[1][0] = 6'd1;
    bus.arn_src[1][1] = 6'd63;
    #1;
    chk("t1_out_valid", 32'(bus.out_valid), 1);
    chk("t1_dst", 32'(bus.prn_dst[0][0]), 33);
    chk("t1_dst_valid", 32'(bus.prn_dst_valid[0][0]), 1);
    chk("t1_dst_nvalid", 32'(bus.prn_dst_valid[0][1]), 0);
    chk("t1_old", 32'(bus.old_prn[0][0]), 1);
    chk("t1_src00", 32'(bus.prn_src[0][0]), 1);
    chk("t1_src00_rdy", 32'(bus.prn_src_ready[0][0]), 1);
    chk("t1_src10_byp", 32'(bus.prn_src[1][0]), 33);
    chk("t1_src10_rdy", 32'(bus.prn_src_ready[1][0]), 0);
    chk("t1_src10_vld", 32'(bus.prn_src_valid[1][0]), 1);
    chk("t1_zero_prn", 32'(bus.prn_src[1][1]), 0);
    chk("t1_zero_rdy", 32'(bus.prn_src_ready[1][1]), 1);
    chk("t1_zero_vld", 32'(bus.prn_src_valid[1][1]), 0);
    chk("t1_none_prn", 32'(bus.prn_src[1][2]), 63);
    chk("t1_none_rdy", 32'(bus.prn_src_ready[1][2]), 0);
    tick();

    // Same ARN written three times in one group
    clear_in();
    chk("t1b_count", 32'(bus.free_count), 30);
    bus.in_valid = 1'b1;
    bus.arn_dst[0][0] = 6'd7;
    bus.arn_dst[0][1] = 6'd7;
    bus.arn_dst[1][0] = 6'd7;
    bus.arn_src[1][0] = 6'd7;
    bus.arn_src[0][0] = 6'd1;
    #1;
    chk("t1b_dst00", 32'(bus.prn_dst[0][0]), 34);
    chk("t1b_dst01", 32'(bus.prn_dst[0][1]), 35);
    chk("t1b_dst10", 32'(bus.prn_dst[1][0]), 36);
    chk("t1b_old00", 32'(bus.old_prn[0][0]), 7);
    chk("t1b_old01", 32'(bus.old_prn[0][1]), 34);
    chk("t1b_old10", 32'(bus.old_prn[1][0]), 35);
    chk("t1b_src10_byp", 32'(bus.prn_src[1][0]), 35);
    chk("t1b_src00", 32'(bus.prn_src[0][0]), 33);
    chk("t1b_src00_rdy", 32'(bus.prn_src_ready[0][0]), 0);
    tick();

    // Stalled group is offered but changes nothing
    clear_in();
    chk("st_count_pre", 32'(bus.free_count), 27);
    bus.in_valid = 1'b1;
    bus.stall = 1'b1;
    bus.arn_dst[0][0] = 6'd2;
    bus.arn_src[0][0] = 6'd7;
    #1;
    chk("st_out_valid", 32'(bus.out_valid), 1);
    chk("st_dst", 32'(bus.prn_dst[0][0]), 37);
    chk("st_src", 32'(bus.prn_src[0][0]), 36);
    tick();

    // Writeback forwarding; allocation beats same-cycle writeback
    clear_in();
    chk("st_count_post", 32'(bus.free_count), 27);
    bus.in_valid = 1'b1;
    bus.arn_src[0][0] = 6'd7;
    bus.arn_dst[0][0] = 6'd2;
    bus.wb_valid[2] = 1'b1;
    bus.wb_prn[2] = 6'd36;
    bus.wb_valid[0] = 1'b1;
    bus.wb_prn[0] = 6'd37;
    #1;
    chk("wb_fwd_rdy", 32'(bus.prn_src_ready[0][0]), 1);
    chk("wb_dst", 32'(bus.prn_dst[0][0]), 37);
    tick();
    clear_in();
    chk("wb_count", 32'(bus.free_count), 26);
    bus.in_valid = 1'b1;
    bus.arn_src[0][0] = 6'd7;
    bus.arn_src[0][1] = 6'd2;
    #1;
    chk("wb_sticky_rdy", 32'(bus.prn_src_ready[0][0]), 1);
    chk("alloc_wins_prn", 32'(bus.prn_src[0][1]), 37);
    chk("alloc_wins_rdy", 32'(bus.prn_src_ready[0][1]), 0);
    tick();

    // Free-list exhaustion and refill
    do_reset();
    for (int g = 0; g < 10; g++) begin
      clear_in();
      bus.in_valid = 1'b1;
      bus.arn_dst[0][0] = 6'd10;
      bus.arn_dst[0][1] = 6'd11;
      bus.arn_dst[1][2] = 6'd12;
      #1;
      chk("fill_out_valid", 32'(bus.out_valid), 1);
      tick();
    end
    clear_in();
    chk("fill_count", 32'(bus.free_count), 1);
    bus.in_valid = 1'b1;
    bus.arn_dst[0][0] = 6'd10;
    bus.arn_dst[0][1] = 6'd11;
    bus.arn_dst[1][2] = 6'd12;
    #1;
    chk("short_blocked", 32'(bus.out_valid), 0);
    tick();
    chk("short_count", 32'(bus.free_count), 1);
    bus.free_valid[0] = 1'b1;
    bus.free_prn[0] = 6'd5;
    bus.free_valid[2] = 1'b1;
    bus.free_prn[2] = 6'd6;
    #1;
    chk("free_cyc_blocked", 32'(bus.out_valid), 0);
    tick();
    bus.free_valid = '0;
    #1;
    chk("refill_count", 32'(bus.free_count), 3);
    chk("refill_fires", 32'(bus.out_valid), 1);
    chk("refill_dst00", 32'(bus.prn_dst[0][0]), 63);
    chk("refill_dst01", 32'(bus.prn_dst[0][1]), 5);
    chk("refill_dst12", 32'(bus.prn_dst[1][2]), 6);
    tick();
    clear_in();
    chk("empty_count", 32'(bus.free_count), 0);
    bus.in_valid = 1'b1;
    bus.arn_dst[0][0] = 6'd63;
    #1;
    chk("empty_n0_fires", 32'(bus.out_valid), 1);
    chk("empty_n0_dstv", 32'(bus.prn_dst_valid[0][0]), 0);
    tick();

    // Checkpoint then flush with concurrent rename and free
    do_reset();
    clear_in();
    bus.in_valid = 1'b1;
    bus.ckpt_req = 1'b1;
    bus.arn_dst[0][0] = 6'd5;
    #1;
    chk("ck_id0", 32'(bus.ckpt_id), 0);
    chk("ck_dst", 32'(bus.prn_dst[0][0]), 33);
    tick();
    clear_in();
    chk("ck_id1", 32'(bus.ckpt_id), 1);
    chk("ck_count", 32'(bus.free_count), 30);
    bus.in_valid = 1'b1;
    bus.arn_dst[0][0] = 6'd5;
    #1;
    chk("spec_dst", 32'(bus.prn_dst[0][0]), 34);
    chk("spec_old", 32'(bus.old_prn[0][0]), 33);
    tick();
    clear_in();
    chk("spec_count", 32'(bus.free_count), 29);
    bus.flush_valid = 1'b1;
    bus.flush_ckpt = 2'd0;
    bus.in_valid = 1'b1;
    bus.arn_dst[0][0] = 6'd9;
    bus.free_valid[1] = 1'b1;
    bus.free_prn[1] = 6'd34;
    #1;
    chk("flush_blocks", 32'(bus.out_valid), 0);
    tick();
    clear_in();
    chk("flush_count", 32'(bus.free_count), 31);
    chk("flush_ckpt_id", 32'(bus.ckpt_id), 1);
    bus.in_valid = 1'b1;
    bus.arn_src[0][0] = 6'd5;
    bus.arn_dst[0][0] = 6'd5;
    #1;
    chk("flush_src_map", 32'(bus.prn_src[0][0]), 33);
    chk("flush_dst_head", 32'(bus.prn_dst[0][0]), 34);
    chk("flush_old", 32'(bus.old_prn[0][0]), 33);
    tick();

    // Checkpoint FIFO limits
    do_reset();
    clear_in();
    bus.ckpt_release = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      clear_in();
      bus.in_valid = 1'b1;
      bus.ckpt_req = 1'b1;
      #1;
      chk("fifo_push_id", 32'(bus.ckpt_id), 32'(c));
      chk("fifo_push_ok", 32'(bus.out_valid), 1);
      tick();
    end
    clear_in();
    bus.in_valid = 1'b1;
    bus.ckpt_req = 1'b1;
    #1;
    chk("fifo_full_block", 32'(bus.out_valid), 0);
    bus.ckpt_req = 1'b0;
    #1;
    chk("fifo_full_noreq", 32'(bus.out_valid), 1);
    bus.ckpt_req = 1'b1;
    bus.ckpt_release = 1'b1;
    #1;
    chk("fifo_rel_cycle", 32'(bus.out_valid), 0);
    tick();
    clear_in();
    bus.in_valid = 1'b1;
    bus.ckpt_req = 1'b1;
    #1;
    chk("fifo_after_rel", 32'(bus.out_valid), 1);
    chk("fifo_after_id", 32'(bus.ckpt_id), 0);
    tick();
    clear_in();
    bus.flush_valid = 1'b1;
    bus.flush_ckpt = 2'd2;
    bus.ckpt_release = 1'b1;
    tick();
    clear_in();
    #1;
    chk("flrel_ckpt_id", 32'(bus.ckpt_id), 3);
    for (int c = 0; c < 3; c++) begin
      clear_in();
      bus.in_valid = 1'b1;
      bus.ckpt_req = 1'b1;
      #1;
      chk("flrel_push_ok", 32'(bus.out_valid), 1);
      chk("flrel_push_id", 32'(bus.ckpt_id), 32'((3 + c) % 4));
      tick();
    end
    clear_in();
    bus.in_valid = 1'b1;
    bus.ckpt_req = 1'b1;
    #1;
    chk("flrel_full", 32'(bus.out_valid), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
